seq_det_param: RTL and testbench
================================

SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 SHALL have parameter PAT_W, default 4, maximum pattern length in bits (legal 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of the match counter.
REQ-003 SHALL have parameter PAT_RST, default 4'b1101 (PAT_W bits), pattern loaded at reset.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port din  input  1  serial data bit.
REQ-007 SHALL have port din_vld  input  1  din sampled only when high.
REQ-008 SHALL have port cfg_we  input  1  loads cfg_pattern, cfg_len and cfg_ovl.
REQ-009 SHALL have port cfg_pattern  input  PAT_W  pattern; first-received bit is bit [cfg_len-1].
REQ-010 SHALL have port cfg_len  input  $clog2(PAT_W+1)  active pattern length.
REQ-011 SHALL have port cfg_ovl  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-012 SHALL have port clr_cnt  input  1  clears match counter.
REQ-013 SHALL have port Y  output  1  registered one-cycle match pulse.
REQ-014 SHALL have port match_cnt  output  CNT_W  saturating count of matches.

Function
REQ-015 SHALL keep a history shift register (PAT_W bits) and fill count; each accepted bit (din_vld=1) shifts in at LSB and increments fill, saturating at active length.
REQ-016 SHALL implement a Moore FSM: S_IDLE (fill=0), S_FILL (0<fill<len), S_ARMED (fill>=len); hold state when din_vld=0.
REQ-017 SHALL raise internal match_evt registered in the cycle after the edge that accepts a bit making the low len history bits equal the low len pattern bits while fill reaches/holds len.
REQ-018 SHALL drive Y = match_evt delayed one register: last pattern bit accepted at edge k -> match_evt high after edge k, Y high after edge k+1 for exactly one cycle.
REQ-019 SHALL, after a match with overlap=1, stay in S_ARMED with history retained; with overlap=0, clear fill and go to S_IDLE so the next match needs len fresh bits.
REQ-020 SHALL never hold Y high for more than one cycle per match, regardless of din_vld gaps.
REQ-021 SHALL clamp cfg_len: values <2 treated as 2, values >PAT_W treated as PAT_W, at load time.
REQ-022 SHALL, on cfg_we, load config, clear history and fill, go to S_IDLE; a din_vld bit in the same cycle is discarded; a pending match_evt/Y pulse still completes.
REQ-023 SHALL increment match_cnt on each match_evt, saturating at 2^CNT_W-1.
REQ-024 SHALL give clr_cnt priority: clr_cnt and match_evt same cycle -> match_cnt=0; Y still pulses.

Reset
REQ-025 SHALL on rst: state S_IDLE, history=0, fill=0, Y=0, match_evt=0, match_cnt=0, pattern=PAT_RST, len=PAT_W, overlap=0.
REQ-026 SHALL let rst override cfg_we, din_vld and clr_cnt in the same cycle; partial sequences are lost.

Structure
REQ-027 SHALL place state encoding (S_IDLE/S_FILL/S_ARMED) and default constants in package seq_det_pkg.
REQ-028 SHALL use one sub-module seq_det_hist (history shift register, fill counter, clamped compare) instantiated by seq_det_param.
REQ-029 SHALL fit in 120-400 lines RTL, FSM coded as state register, next-state logic, registered output.

Verification
REQ-030 SHALL test default 1101, ovl=0: din 1,1,0,1 vld each cycle -> one Y pulse two edges after last bit, match_cnt=1.
REQ-031 SHALL test din 1,1,0,1,1,0,1: ovl=1 -> two Y pulses, match_cnt=2; ovl=0 -> one pulse, match_cnt=1.
REQ-032 SHALL test vld gaps: 1,(gap),1,0,(gap x3),1 -> exactly one one-cycle Y pulse, match_cnt=1.
REQ-033 SHALL test cfg_we pattern 010 len 3 ovl=1 after bits 1,1 -> then 0,1,0,1,0 gives two pulses; same-cycle din discarded.
REQ-034 SHALL test CNT_W=2, five matches -> five Y pulses, match_cnt=3; clr_cnt with match -> match_cnt=0.
REQ-035 SHALL test rst after 1,1,0 then din 1 -> no Y, match_cnt=0, pattern back to 1101.

Source files
------------

// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the parameterised serial sequence detector:
//   - state_t    : detector FSM encoding (S_IDLE / S_FILL / S_ARMED)
//   - DEF_*      : default parameter values for seq_det_param
//   - clamp_len  : folds a requested pattern length into the legal range
// ---------------------------------------------------------------------------
package seq_det_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,   // no bits collected
        S_FILL  = 2'd1,   // some bits collected, fewer than the active length
        S_ARMED = 2'd2    // at least the active length collected
    } state_t;

    localparam int         DEF_PAT_W   = 4;
    localparam int         DEF_CNT_W   = 8;
    localparam logic [3:0] DEF_PAT_RST = 4'b1101;

    // Lengths below 2 or above the history width are meaningless for the
    // compare; fold them onto the nearest legal value.
    function automatic int clamp_len(input int len, input int pat_w);
        if (len < 2)
            return 2;
        else if (len > pat_w)
            return pat_w;
        return len;
    endfunction

endpackage

// File: rtl/seq_det_hist.sv
// ---------------------------------------------------------------------------
// seq_det_hist
// History shift register, fill counter and length-masked pattern compare.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_clr         : clear history and fill (config load / non-overlap match)
//   i_shift       : accept i_din this cycle
//   i_din         : serial data bit
//   i_pat, i_len  : active pattern and (already clamped) length
//   o_hit         : accepting i_din now completes a match
//   o_full_nxt    : fill count after accepting i_din equals the length
// ---------------------------------------------------------------------------
module seq_det_hist
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_shift,
    input  logic             i_din,
    input  logic [PAT_W-1:0] i_pat,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_hit,
    output logic             o_full_nxt
);

    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;

    logic [PAT_W-1:0] w_hist_nxt;
    logic [LEN_W-1:0] w_fill_nxt;
    logic [PAT_W-1:0] w_mask;

    always_comb begin
        // Newest bit enters at the LSB, so the low len bits hold the most
        // recent len bits with the oldest at bit [len-1].
        w_hist_nxt = (r_hist << 1) | {{(PAT_W-1){1'b0}}, i_din};
        w_fill_nxt = (r_fill >= i_len) ? i_len : r_fill + 1'b1;
        for (int i = 0; i < PAT_W; i++)
            w_mask[i] = (i < int'(i_len));
        o_full_nxt = (w_fill_nxt == i_len);
        o_hit      = i_shift && o_full_nxt &&
                     (((w_hist_nxt ^ i_pat) & w_mask) == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_shift) begin
            r_hist <= w_hist_nxt;
            r_fill <= w_fill_nxt;
        end
    end

endmodule

// File: rtl/seq_det_param.sv
// ---------------------------------------------------------------------------
// seq_det_param
// Configurable serial pattern detector with overlapping / non-overlapping
// modes, registered one-cycle match pulse and saturating match counter.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   din, din_vld    : serial data bit and its qualifier
//   cfg_we          : load cfg_pattern / cfg_len / cfg_ovl, restart detection
//   cfg_pattern     : pattern, first-received bit at [cfg_len-1]
//   cfg_len         : active pattern length (clamped to 2..PAT_W)
//   cfg_ovl         : 1 = overlapping detection
//   clr_cnt         : clear match counter (wins over a same-cycle match)
//   Y               : one-cycle match pulse, two edges after the last bit
//   match_cnt       : saturating match count
// ---------------------------------------------------------------------------
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter int               CNT_W   = DEF_CNT_W,
    parameter logic [PAT_W-1:0] PAT_RST = DEF_PAT_RST
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         din,
    input  logic                         din_vld,
    input  logic                         cfg_we,
    input  logic [PAT_W-1:0]             cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
    input  logic                         cfg_ovl,
    input  logic                         clr_cnt,
    output logic                         Y,
    output logic [CNT_W-1:0]             match_cnt
);

    localparam int LEN_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic             r_ovl;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_evt;
    logic             r_y;
    logic [CNT_W-1:0] r_cnt;

    logic w_acc;
    logic w_hit;
    logic w_full_nxt;
    logic w_hist_clr;

    // A bit arriving together with a config load is dropped.
    assign w_acc      = din_vld & ~cfg_we;
    // Non-overlapping mode restarts collection after every match.
    assign w_hist_clr = cfg_we | (w_hit & ~r_ovl);

    seq_det_hist #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_hist (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clr      (w_hist_clr),
        .i_shift    (w_acc),
        .i_din      (din),
        .i_pat      (r_pat),
        .i_len      (r_len),
        .o_hit      (w_hit),
        .o_full_nxt (w_full_nxt)
    );

    // Configuration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat <= PAT_RST;
            r_len <= LEN_W'(PAT_W);
            r_ovl <= 1'b0;
        end else if (cfg_we) begin
            r_pat <= cfg_pattern;
            r_len <= LEN_W'(clamp_len(int'(cfg_len), PAT_W));
            r_ovl <= cfg_ovl;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM next-state logic; state only moves on accepted bits or config load
    always_comb begin
        w_state_nxt = r_state;
        if (cfg_we)
            w_state_nxt = S_IDLE;
        else if (din_vld) begin
            if (w_hit && !r_ovl)
                w_state_nxt = S_IDLE;
            else if (w_full_nxt)
                w_state_nxt = S_ARMED;
            else
                w_state_nxt = S_FILL;
        end
    end

    // Match event, delayed output pulse and saturating counter.
    // A pending event/pulse is deliberately not cancelled by cfg_we.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_evt <= 1'b0;
            r_y   <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_evt <= w_hit;
            r_y   <= r_evt;
            if (clr_cnt)
                r_cnt <= '0;
            else if (r_evt && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign Y         = r_y;
    assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_det_param.sv
module tb_seq_det_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       din_vld;
    logic       cfg_we;
    logic [3:0] cfg_pattern;
    logic [2:0] cfg_len;
    logic       cfg_ovl;
    logic       clr_cnt;
    logic       Y;
    logic [7:0] match_cnt;
    logic       Y2;
    logic [1:0] cnt2;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int pulses2 = 0;
    int base;
    int base2;

    always #5 clk = ~clk;

    seq_det_param dut (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
        .clr_cnt(clr_cnt), .Y(Y), .match_cnt(match_cnt)
    );

    seq_det_param #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
        .clr_cnt(clr_cnt), .Y(Y2), .match_cnt(cnt2)
    );

    // Pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (Y === 1'b1) pulses++;
        if (Y2 === 1'b1) pulses2++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        din = b;
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        din = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic cfg(input logic [3:0] p, input logic [2:0] l, input logic o);
        cfg_pattern = p;
        cfg_len = l;
        cfg_ovl = o;
        cfg_we = 1'b1;
        clr_cnt = 1'b1;
        tick();
        cfg_we = 1'b0;
        clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        checks++; if (Y !== 1'b0) begin errors++; $display("FAIL reset_y: got %b want 0", Y); end
        checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", match_cnt); end
        checks++; if (cnt2 !== 2'd0) begin errors++; $display("FAIL reset_cnt2: got %0d want 0", cnt2); end
    endtask

    task automatic test_basic();
        base = pulses;
        send(1); send(1); send(0); send(1);
        checks++; if (Y !== 1'b0) begin errors++; $display("FAIL basic_y_k: got %b want 0", Y); end
        tick();
        checks++; if (Y !== 1'b1) begin errors++; $display("FAIL basic_y_k1: got %b want 1", Y); end
        checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL basic_cnt_k1: got %0d want 1", match_cnt); end
        tick();
        checks++; if (Y !== 1'b0) begin errors++; $display("FAIL basic_y_k2: got %b want 0", Y); end
        idle(2);
        checks++; if (pulses - base !== 1) begin errors++; $display("FAIL basic_pulses: got %0d want 1", pulses - base); end
        checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL basic_cnt: got %0d want 1", match_cnt); end
    endtask

    task automatic test_overlap();
        logic seq [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        cfg(4'b1101, 3'd4, 1'b1);
        base = pulses;
        foreach (seq[i]) send(seq[i]);
        idle(3);
        checks++; if (pulses - base !== 2) begin errors++; $display("FAIL ovl1_pulses: got %0d want 2", pulses - base); end
        checks++; if (match_cnt !== 8'd2) begin errors++; $display("FAIL ovl1_cnt: got %0d want 2", match_cnt); end
        cfg(4'b1101, 3'd4, 1'b0);
        base = pulses;
        foreach (seq[i]) send(seq[i]);
        idle(3);
        checks++; if (pulses - base !== 1) begin errors++; $display("FAIL ovl0_pulses: got %0d want 1", pulses - base); end
        checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL ovl0_cnt: got %0d want 1", match_cnt); end
    endtask

    task automatic test_gaps();
        cfg(4'b1101, 3'd4, 1'b0);
        base = pulses;
        send(1); idle(1); send(1); send(0); idle(3); send(1);
        checks++; if (Y !== 1'b0) begin errors++; $display("FAIL gap_y_k: got %b want 0", Y); end
        tick();
        checks++; if (Y !== 1'b1) begin errors++; $display("FAIL gap_y_k1: got %b want 1", Y); end
        tick();
        checks++; if (Y !== 1'b0) begin errors++; $display("FAIL gap_y_k2: got %b want 0", Y); end
        idle(3);
        checks++; if (pulses - base !== 1) begin errors++; $display("FAIL gap_pulses: got %0d want 1", pulses - base); end
        checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL gap_cnt: got %0d want 1", match_cnt); end
    endtask

    task automatic test_cfg_change();
        logic seq [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        cfg(4'b1101, 3'd4, 1'b0);
        send(1); send(1);
        // Load 010/len3/ovl with a bit offered in the same cycle
        cfg_pattern = 4'b0010; cfg_len = 3'd3; cfg_ovl = 1'b1;
        cfg_we = 1'b1; clr_cnt = 1'b1; din = 1'b0; din_vld = 1'b1;
        tick();
        cfg_we = 1'b0; clr_cnt = 1'b0; din_vld = 1'b0;
        base = pulses;
        foreach (seq[i]) send(seq[i]);
        idle(3);
        checks++; if (pulses - base !== 2) begin errors++; $display("FAIL cfg_pulses: got %0d want 2", pulses - base); end
        checks++; if (match_cnt !== 8'd2) begin errors++; $display("FAIL cfg_cnt: got %0d want 2", match_cnt); end
        // Same-cycle 0 must be discarded: 1,0 alone is then too short
        cfg_we = 1'b1; din = 1'b0; din_vld = 1'b1;
        tick();
        cfg_we = 1'b0; din_vld = 1'b0;
        base = pulses;
        send(1); send(0);
        idle(3);
        checks++; if (pulses - base !== 0) begin errors++; $display("FAIL cfg_discard: got %0d want 0", pulses - base); end
        // Pending pulse survives a config load
        cfg(4'b1101, 3'd4, 1'b0);
        send(1); send(1); send(0); send(1);
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        checks++; if (Y !== 1'b1) begin errors++; $display("FAIL cfg_pending_y: got %b want 1", Y); end
        idle(2);
    endtask

    task automatic test_clamp();
        cfg(4'b0011, 3'd0, 1'b1);
        base = pulses;
        send(1); idle(2);
        checks++; if (pulses - base !== 0) begin errors++; $display("FAIL clamp_lo_early: got %0d want 0", pulses - base); end
        send(1); idle(2);
        checks++; if (pulses - base !== 1) begin errors++; $display("FAIL clamp_lo: got %0d want 1", pulses - base); end
        cfg(4'b1101, 3'd7, 1'b0);
        base = pulses;
        send(1); send(1); send(0); send(1); idle(2);
        checks++; if (pulses - base !== 1) begin errors++; $display("FAIL clamp_hi: got %0d want 1", pulses - base); end
    endtask

    task automatic test_sat();
        cfg(4'b1101, 3'd4, 1'b0);
        base2 = pulses2;
        repeat (5) begin send(1); send(1); send(0); send(1); end
        idle(2);
        checks++; if (pulses2 - base2 !== 5) begin errors++; $display("FAIL sat_pulses: got %0d want 5", pulses2 - base2); end
        checks++; if (cnt2 !== 2'd3) begin errors++; $display("FAIL sat_cnt2: got %0d want 3", cnt2); end
        checks++; if (match_cnt !== 8'd5) begin errors++; $display("FAIL sat_cnt8: got %0d want 5", match_cnt); end
        send(1); send(1); send(0); send(1);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++; if (cnt2 !== 2'd0) begin errors++; $display("FAIL clr_cnt2: got %0d want 0", cnt2); end
        checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL clr_cnt8: got %0d want 0", match_cnt); end
        checks++; if (Y2 !== 1'b1) begin errors++; $display("FAIL clr_y2: got %b want 1", Y2); end
        tick();
        checks++; if (cnt2 !== 2'd0) begin errors++; $display("FAIL clr_cnt2_after: got %0d want 0", cnt2); end
        idle(2);
    endtask

    task automatic test_rst_partial();
        cfg(4'b1011, 3'd4, 1'b0);
        send(1); send(1); send(0);
        rst = 1'b1; din = 1'b1; din_vld = 1'b1; cfg_we = 1'b1; clr_cnt = 1'b1;
        tick();
        rst = 1'b0; din_vld = 1'b0; cfg_we = 1'b0; clr_cnt = 1'b0;
        base = pulses;
        send(1); idle(2);
        checks++; if (pulses - base !== 0) begin errors++; $display("FAIL rst_no_y: got %0d want 0", pulses - base); end
        checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", match_cnt); end
        // Completes 1101 only if the reset pattern is back in place
        send(1); send(0); send(1); idle(2);
        checks++; if (pulses - base !== 1) begin errors++; $display("FAIL rst_pattern: got %0d want 1", pulses - base); end
        checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL rst_pattern_cnt: got %0d want 1", match_cnt); end
    endtask

    initial begin
        rst = 1'b0; din = 1'b0; din_vld = 1'b0; cfg_we = 1'b0;
        cfg_pattern = 4'b1101; cfg_len = 3'd4; cfg_ovl = 1'b0; clr_cnt = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_overlap();
        test_gaps();
        test_cfg_change();
        test_clamp();
        test_sat();
        test_rst_partial();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
